multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Second-generation CPU controller: instruction register, decoder and Moore control FSM driving the existing datapath. It adds LDR/STR with a req/ack memory handshake, HALT, illegal-opcode detection and a width-parametrised immediate path. It sits between the instruction source or testbench and the datapath plus memory. All datapath strobes are decoded from the current state, so they are valid in the same cycle as the state.

Parameters:
DW, 16, datapath width; sximm5/sximm8 are sign-extended to DW bits
MEM_TIMEOUT, 15, max cycles waiting for mem_ack (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
s  in  1  start; sampled only in WAIT
load  in  1  IR load enable; honoured only in WAIT
in  in  16  instruction word
mem_ack  in  1  memory completes the current request
w  out  1  1 only in WAIT
halted  out  1  1 only in HALT
illegal  out  1  one-cycle pulse in the cycle after DECODE saw an undefined opcode
err  out  1  sticky memory-timeout flag (optional feature; else tied 0)
readnum, writenum  out  3  register index chosen by nsel
vsel  out  4  one-hot writeback source: 0001 C, 0010 PC, 0100 sximm8, 1000 mdata
asel, bsel, loada, loadb, loadc, loads, write  out  1  datapath strobes
load_addr  out  1  latch C into the address register
mem_req, mem_we  out  1  memory request and write qualifier
ALUop, shift  out  2  ALUop=IR[12:11]; shift=IR[4:3], forced to 00 in STR_C
sximm5, sximm8  out  DW  sign-extended IR[4:0] and IR[7:0]

Behaviour:
- IR field layout: opc[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0].
- IR: captured at a clk edge when load=1 and state=WAIT; held otherwise. Reset value 0.
- Reset: state=WAIT, IR=0, err=0. All strobes 0, vsel=0001, w=1, halted=0, illegal=0.
- Idle levels: every strobe not listed for a state is 0; vsel=0001 unless listed.
- nsel: Rn in GET_A/LDR_A/MOVIMM; Rm in GET_B; Rd in WR_RD/STR_B/WR_MEM. readnum and writenum both follow nsel. Default is Rn.
- WAIT: if s=1, go to DECODE; otherwise stay.
- DECODE transitions:
  - 110/10 (MOV imm) -> MOVIMM
  - 110/00 (MOV shift) -> GET_B
  - 101/00, 101/01, 101/10 (ADD, CMP, AND) -> GET_A
  - 101/11 (MVN) -> GET_B
  - 011/00 (LDR) -> LDR_A
  - 100/00 (STR) -> LDR_A
  - 111 (HALT) -> HALT
  - anything else -> WAIT with illegal=1 for one cycle
- GET_A: loada. Next state is GET_B.
- GET_B: loadb. Next state is SHIFT for MOV/MVN, STATUS for CMP, ALU for ADD/AND.
- ALU: loadc. Next state is WR_RD.
- SHIFT: asel, loadc. Next state is WR_RD.
- STATUS: loads. Next state is WAIT.
- WR_RD: write, vsel=0001. Next state is WAIT.
- MOVIMM: write, vsel=0100. Next state is WAIT.
- LDR_A: loada. Next state is ADDR.
- ADDR: bsel, loadc (C = Rn + sximm5). Next state is LD_ADDR.
- LD_ADDR: load_addr. Next state is MEM_RD for LDR, STR_B for STR.
- MEM_RD: mem_req=1, mem_we=0; hold until mem_ack=1, then WR_MEM.
- WR_MEM: write, vsel=1000. Next state is WAIT.
- STR_B: loadb. Next state is STR_C.
- STR_C: asel, loadc, shift=00. Next state is MEM_WR.
- MEM_WR: mem_req=1, mem_we=1; hold until mem_ack=1, then WAIT.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- HALT: absorbing; only reset exits. s and load are ignored.
- Cycle counts, DECODE through last state inclusive:
  - ADD/AND 5; CMP 4; MVN/MOV-shift 4; MOV imm 2
  - LDR 6 + wait cycles; STR 7 + wait cycles
- Reset asserted mid-instruction: next edge returns to WAIT; any outstanding mem_req drops that cycle.

Optional Feature:
CTRL_MEM_TIMEOUT_EN
- Defined: a counter clears on entry to MEM_RD/MEM_WR and increments each cycle without mem_ack. On reaching MEM_TIMEOUT, the FSM goes to WAIT, skips the register write, and sets err=1. err clears only on reset.
- Undefined: no counter; the FSM waits for mem_ack indefinitely; err is tied 0.

Test Plan:
- Reset, then load 0xD107 (MOV R1,#7), pulse s -> MOVIMM one cycle after DECODE with vsel=0100, writenum=1, sximm8=0x0007; w returns 1 two cycles after DECODE.
- Load 0xA0A1 (ADD R5,R0,R1) -> DECODE, GET_A (readnum 0), GET_B (readnum 1), ALU, WR_RD (writenum 5, write=1), then WAIT.
- Load 0x6243 (LDR R2,[R2,#3]), hold mem_ack=0 for 3 cycles in MEM_RD -> mem_req stays 1 and mem_we 0 for 4 cycles; then WR_MEM with vsel=1000, writenum=2.
- Load 0x8218 (STR R0,[R2,#-8]) -> sximm5=0xFFF8 in ADDR; STR_C shift=00 despite IR[4:3]=11; MEM_WR mem_we=1 until ack.
- Load 0x0000 -> illegal pulses once, FSM back in WAIT; then load 0xE000 -> halted=1, w=0, s ignored until reset.
- With CTRL_MEM_TIMEOUT_EN and MEM_TIMEOUT=15, run LDR with no ack -> after 15 MEM_RD cycles return to WAIT, err=1, no write strobe.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundles every non-clock/reset signal of the multicycle CPU controller.
//
//   master modport (instruction source / bench side):
//     drives   s, load, in, mem_ack
//     observes w, halted, illegal, err, readnum, writenum, vsel, asel, bsel,
//              loada, loadb, loadc, loads, write, load_addr, mem_req, mem_we,
//              ALUop, shift, sximm5, sximm8
//   slave modport (controller side): the same signals with directions reversed.
//
// DW is the datapath width used for the sign-extended immediates.
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int DW = 16
);
    logic                 s;
    logic                 load;
    logic [15:0]          in;
    logic                 mem_ack;

    logic                 w;
    logic                 halted;
    logic                 illegal;
    logic                 err;
    logic [2:0]           readnum;
    logic [2:0]           writenum;
    logic [3:0]           vsel;
    logic                 asel;
    logic                 bsel;
    logic                 loada;
    logic                 loadb;
    logic                 loadc;
    logic                 loads;
    logic                 write;
    logic                 load_addr;
    logic                 mem_req;
    logic                 mem_we;
    logic [1:0]           ALUop;
    logic [1:0]           shift;
    logic signed [DW-1:0] sximm5;
    logic signed [DW-1:0] sximm8;

    modport master (
        output s, load, in, mem_ack,
        input  w, halted, illegal, err, readnum, writenum, vsel,
               asel, bsel, loada, loadb, loadc, loads, write,
               load_addr, mem_req, mem_we, ALUop, shift, sximm5, sximm8
    );

    modport slave (
        input  s, load, in, mem_ack,
        output w, halted, illegal, err, readnum, writenum, vsel,
               asel, bsel, loada, loadb, loadc, loads, write,
               load_addr, mem_req, mem_we, ALUop, shift, sximm5, sximm8
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Instruction register, decoder and Moore control FSM for the multicycle CPU
// datapath. Every datapath strobe is decoded from the current state only, so
// strobes are valid in the same cycle as the state that asserts them.
//
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset (state -> WAIT, IR -> 0, err -> 0)
//   bus    : multicycle_ctrl_if.slave
//            inputs  s (start), load (IR load), in (instruction), mem_ack
//            outputs w, halted, illegal, err, readnum/writenum, vsel,
//                    asel, bsel, loada, loadb, loadc, loads, write,
//                    load_addr, mem_req, mem_we, ALUop, shift, sximm5, sximm8
//
// Parameters:
//   DW          : datapath width of the sign-extended immediates
//   MEM_TIMEOUT : cycles allowed in MEM_RD/MEM_WR without mem_ack
//
// Optional feature macro: CTRL_MEM_TIMEOUT_EN
//   defined   : a memory wait longer than MEM_TIMEOUT cycles abandons the
//               access, returns to WAIT without a register write and sets
//               the sticky err flag (cleared only by reset)
//   undefined : memory waits are unbounded and err is constant 0
// ----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int DW          = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.slave  bus
);

    localparam logic [4:0] S_WAIT    = 5'd0;
    localparam logic [4:0] S_DECODE  = 5'd1;
    localparam logic [4:0] S_GET_A   = 5'd2;
    localparam logic [4:0] S_GET_B   = 5'd3;
    localparam logic [4:0] S_ALU     = 5'd4;
    localparam logic [4:0] S_SHIFT   = 5'd5;
    localparam logic [4:0] S_STATUS  = 5'd6;
    localparam logic [4:0] S_WR_RD   = 5'd7;
    localparam logic [4:0] S_MOVIMM  = 5'd8;
    localparam logic [4:0] S_LDR_A   = 5'd9;
    localparam logic [4:0] S_ADDR    = 5'd10;
    localparam logic [4:0] S_LD_ADDR = 5'd11;
    localparam logic [4:0] S_MEM_RD  = 5'd12;
    localparam logic [4:0] S_WR_MEM  = 5'd13;
    localparam logic [4:0] S_STR_B   = 5'd14;
    localparam logic [4:0] S_STR_C   = 5'd15;
    localparam logic [4:0] S_MEM_WR  = 5'd16;
    localparam logic [4:0] S_HALT    = 5'd17;

    // Register-index source selection
    localparam logic [1:0] NS_RN = 2'd0;
    localparam logic [1:0] NS_RM = 2'd1;
    localparam logic [1:0] NS_RD = 2'd2;

    function automatic logic signed [DW-1:0] sext5(input logic [4:0] f);
        return $signed({{(DW-5){f[4]}}, f});
    endfunction

    function automatic logic signed [DW-1:0] sext8(input logic [7:0] f);
        return $signed({{(DW-8){f[7]}}, f});
    endfunction

    logic [4:0]  state;
    logic [4:0]  state_nxt;
    logic [15:0] ir;
    logic        ill_set;
    logic        ill_q;
    logic        tmo_hit;
    logic        err_q;
    logic        in_mem;

    logic [2:0]  opc;
    logic [1:0]  op;
    logic        is_shift_op;
    logic        is_cmp;
    logic        is_ldr;

    logic [1:0]  nsel;
    logic        shift_zero;
    logic        w_c, halted_c, write_c, loada_c, loadb_c, loadc_c, loads_c;
    logic        asel_c, bsel_c, load_addr_c, mem_req_c, mem_we_c;
    logic [3:0]  vsel_c;
    logic [2:0]  regnum;

    assign opc         = ir[15:13];
    assign op          = ir[12:11];
    // MOV-shift and MVN route through SHIFT, CMP ends in STATUS
    assign is_shift_op = (opc == 3'b110) || (opc == 3'b101 && op == 2'b11);
    assign is_cmp      = (opc == 3'b101) && (op == 2'b01);
    assign is_ldr      = (opc == 3'b011);
    assign in_mem      = (state == S_MEM_RD) || (state == S_MEM_WR);

    // Instruction register: only writable while idling in WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= '0;
        end else if (state == S_WAIT && bus.load) begin
            ir <= bus.in;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Illegal-opcode pulse lands in the cycle after DECODE
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_set;
        end
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    // Counts cycles spent in a memory state; value k means k+1-th cycle there
    localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (!in_mem) begin
            tmo_cnt <= '0;
        end else if (!bus.mem_ack) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Fires in the MEM_TIMEOUT-th consecutive cycle without an ack
    assign tmo_hit = in_mem && !bus.mem_ack &&
                     (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    // No timeout hardware in this build; expression is constant 0
    assign err_q   = (MEM_TIMEOUT < 0);
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        ill_set   = 1'b0;
        case (state)
            S_WAIT: begin
                if (bus.s) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = S_WAIT;
                case (opc)
                    3'b110: begin
                        if (op == 2'b10)      state_nxt = S_MOVIMM;
                        else if (op == 2'b00) state_nxt = S_GET_B;
                        else                  ill_set   = 1'b1;
                    end
                    3'b101: begin
                        if (op == 2'b11) state_nxt = S_GET_B;
                        else             state_nxt = S_GET_A;
                    end
                    3'b011, 3'b100: begin
                        if (op == 2'b00) state_nxt = S_LDR_A;
                        else             ill_set   = 1'b1;
                    end
                    3'b111:  state_nxt = S_HALT;
                    default: ill_set   = 1'b1;
                endcase
            end
            S_GET_A:   state_nxt = S_GET_B;
            S_GET_B: begin
                if (is_shift_op) state_nxt = S_SHIFT;
                else if (is_cmp) state_nxt = S_STATUS;
                else             state_nxt = S_ALU;
            end
            S_ALU:     state_nxt = S_WR_RD;
            S_SHIFT:   state_nxt = S_WR_RD;
            S_STATUS:  state_nxt = S_WAIT;
            S_WR_RD:   state_nxt = S_WAIT;
            S_MOVIMM:  state_nxt = S_WAIT;
            S_LDR_A:   state_nxt = S_ADDR;
            S_ADDR:    state_nxt = S_LD_ADDR;
            S_LD_ADDR: state_nxt = is_ldr ? S_MEM_RD : S_STR_B;
            S_MEM_RD: begin
                if (bus.mem_ack)  state_nxt = S_WR_MEM;
                else if (tmo_hit) state_nxt = S_WAIT;
            end
            S_WR_MEM:  state_nxt = S_WAIT;
            S_STR_B:   state_nxt = S_STR_C;
            S_STR_C:   state_nxt = S_MEM_WR;
            S_MEM_WR: begin
                if (bus.mem_ack || tmo_hit) state_nxt = S_WAIT;
            end
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_WAIT;
        endcase
    end

    // Moore output decode
    always_comb begin
        w_c         = 1'b0;
        halted_c    = 1'b0;
        write_c     = 1'b0;
        loada_c     = 1'b0;
        loadb_c     = 1'b0;
        loadc_c     = 1'b0;
        loads_c     = 1'b0;
        asel_c      = 1'b0;
        bsel_c      = 1'b0;
        load_addr_c = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        vsel_c      = 4'b0001;
        nsel        = NS_RN;
        shift_zero  = 1'b0;
        case (state)
            S_WAIT:    w_c = 1'b1;
            S_HALT:    halted_c = 1'b1;
            S_GET_A:   loada_c = 1'b1;
            S_LDR_A:   loada_c = 1'b1;
            S_GET_B: begin
                loadb_c = 1'b1;
                nsel    = NS_RM;
            end
            S_ALU:     loadc_c = 1'b1;
            S_SHIFT: begin
                asel_c  = 1'b1;
                loadc_c = 1'b1;
            end
            S_STATUS:  loads_c = 1'b1;
            S_WR_RD: begin
                write_c = 1'b1;
                nsel    = NS_RD;
            end
            S_MOVIMM: begin
                write_c = 1'b1;
                vsel_c  = 4'b0100;
            end
            S_ADDR: begin
                bsel_c  = 1'b1;
                loadc_c = 1'b1;
            end
            S_LD_ADDR: load_addr_c = 1'b1;
            S_MEM_RD:  mem_req_c = 1'b1;
            S_WR_MEM: begin
                write_c = 1'b1;
                vsel_c  = 4'b1000;
                nsel    = NS_RD;
            end
            S_STR_B: begin
                loadb_c = 1'b1;
                nsel    = NS_RD;
            end
            // Store data passes through the shifter unshifted
            S_STR_C: begin
                asel_c     = 1'b1;
                loadc_c    = 1'b1;
                shift_zero = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (nsel)
            NS_RM:   regnum = ir[2:0];
            NS_RD:   regnum = ir[7:5];
            default: regnum = ir[10:8];
        endcase
    end

    assign bus.w         = w_c;
    assign bus.halted    = halted_c;
    assign bus.illegal   = ill_q;
    assign bus.err       = err_q;
    assign bus.readnum   = regnum;
    assign bus.writenum  = regnum;
    assign bus.vsel      = vsel_c;
    assign bus.asel      = asel_c;
    assign bus.bsel      = bsel_c;
    assign bus.loada     = loada_c;
    assign bus.loadb     = loadb_c;
    assign bus.loadc     = loadc_c;
    assign bus.loads     = loads_c;
    assign bus.write     = write_c;
    assign bus.load_addr = load_addr_c;
    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.ALUop     = ir[12:11];
    assign bus.shift     = shift_zero ? 2'b00 : ir[4:3];
    assign bus.sximm5    = sext5(ir[4:0]);
    assign bus.sximm8    = sext8(ir[7:0]);

endmodule
